// File: rtl/reg_file_32x64_pkg.sv
// Shared register-file definitions: address/data geometry, zero-register index
// and the saturating write-counter helper.
package processor_defs;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned XZR_IDX    = 31;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned CNT_W      = 16;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/reg_file_32x64_if.sv
// Read/write port bundle of the register file; master drives addresses and
// write data, slave returns read data and the write counter.
interface reg_file_32x64_if #(
  parameter int unsigned WIDTH = processor_defs::DATA_W
);
  import processor_defs::*;

  logic [REG_ADDR_W-1:0] ReadSelect1;
  logic [REG_ADDR_W-1:0] ReadSelect2;
  logic [REG_ADDR_W-1:0] WriteSelect;
  logic [WIDTH-1:0]      WriteData;
  logic                  RegWrite;
  logic [WIDTH-1:0]      ReadData1;
  logic [WIDTH-1:0]      ReadData2;
  logic [CNT_W-1:0]      WriteCount;

  modport master (
    output ReadSelect1, ReadSelect2, WriteSelect, WriteData, RegWrite,
    input  ReadData1, ReadData2, WriteCount
  );

  modport slave (
    input  ReadSelect1, ReadSelect2, WriteSelect, WriteData, RegWrite,
    output ReadData1, ReadData2, WriteCount
  );

endinterface

// File: rtl/reg_file_32x64_decoder.sv
// 5-bit address plus enable to 32-bit one-hot write strobe; all-zero when
// disabled. The zero register is not special-cased here.
module decoder5to32
  import processor_defs::*;
(
  input  logic [REG_ADDR_W-1:0] i_addr,
  input  logic                  i_en,
  output logic [NUM_REGS-1:0]   o_strobe_c
);

  always_comb begin
    o_strobe_c = '0;
    if (i_en) o_strobe_c[i_addr] = 1'b1;
  end

endmodule

// File: rtl/reg_file_32x64_mux.sv
// 32:1 selector of N-bit words, used for each register-file read port.
module Mux32to1Nbit
  import processor_defs::*;
#(
  parameter int unsigned N = DATA_W
) (
  input  logic [NUM_REGS-1:0][N-1:0] i_data,
  input  logic [REG_ADDR_W-1:0]      i_sel,
  output logic [N-1:0]               o_data_c
);

  assign o_data_c = i_data[i_sel];

endmodule

// File: rtl/reg_file_32x64.sv
// 32 x WIDTH register file: two combinational read ports with optional
// write-through bypass, one clocked write port, hardwired zero register.
module reg_file_32x64
  import processor_defs::*;
#(
  parameter int unsigned WIDTH    = DATA_W,
  parameter bit          BYPASS   = 1'b1,
  parameter int unsigned ZERO_REG = XZR_IDX
) (
  input  logic             clock,
  input  logic             reset,
  reg_file_32x64_if.slave  bus
);

  localparam logic [REG_ADDR_W-1:0] ZR_ADDR = REG_ADDR_W'(ZERO_REG);
  localparam logic [NUM_REGS-1:0]   ZR_MASK = ~(NUM_REGS'(1) << ZERO_REG);

  logic [NUM_REGS-1:0]            w_strobe_raw;
  logic [NUM_REGS-1:0]            w_strobe;
  logic                           w_commit;
  logic [NUM_REGS-1:0][WIDTH-1:0] r_regs;
  logic [CNT_W-1:0]               r_write_count;
  logic [WIDTH-1:0]               w_mux1;
  logic [WIDTH-1:0]               w_mux2;
  logic                           w_byp1;
  logic                           w_byp2;

  decoder5to32 u_dec (
    .i_addr     (bus.WriteSelect),
    .i_en       (bus.RegWrite),
    .o_strobe_c (w_strobe_raw)
  );

  assign w_strobe = w_strobe_raw & ZR_MASK;
  assign w_commit = |w_strobe;

  // One enabled, async-cleared register per index
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    always_ff @(posedge clock or posedge reset) begin
      if (reset)            r_regs[g] <= '0;
      else if (w_strobe[g]) r_regs[g] <= bus.WriteData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_write_count <= '0;
    else if (w_commit) r_write_count <= sat_inc(r_write_count);
  end

  Mux32to1Nbit #(.N(WIDTH)) u_mux1 (
    .i_data   (r_regs),
    .i_sel    (bus.ReadSelect1),
    .o_data_c (w_mux1)
  );

  Mux32to1Nbit #(.N(WIDTH)) u_mux2 (
    .i_data   (r_regs),
    .i_sel    (bus.ReadSelect2),
    .o_data_c (w_mux2)
  );

  // Bypass is suppressed during reset so reads stay zero while it is held
  assign w_byp1 = BYPASS && !reset && bus.RegWrite && (bus.WriteSelect == bus.ReadSelect1);
  assign w_byp2 = BYPASS && !reset && bus.RegWrite && (bus.WriteSelect == bus.ReadSelect2);

  assign bus.ReadData1  = (bus.ReadSelect1 == ZR_ADDR) ? '0 :
                          w_byp1                       ? bus.WriteData : w_mux1;
  assign bus.ReadData2  = (bus.ReadSelect2 == ZR_ADDR) ? '0 :
                          w_byp2                       ? bus.WriteData : w_mux2;
  assign bus.WriteCount = r_write_count;

endmodule

// File: tb/tb_reg_file_32x64.sv
// Directed bench for reg_file_32x64: a bypassing and a non-bypassing instance
// share one stimulus so forwarding behaviour can be compared side by side.
module tb_reg_file_32x64;

  logic        clock;
  logic        reset;
  logic [4:0]  rs1, rs2, ws;
  logic [63:0] wd;
  logic        we;

  int total;
  int bad;

  reg_file_32x64_if #(.WIDTH(64)) bus_b ();
  reg_file_32x64_if #(.WIDTH(64)) bus_n ();

  assign bus_b.ReadSelect1 = rs1;
  assign bus_b.ReadSelect2 = rs2;
  assign bus_b.WriteSelect = ws;
  assign bus_b.WriteData   = wd;
  assign bus_b.RegWrite    = we;
  assign bus_n.ReadSelect1 = rs1;
  assign bus_n.ReadSelect2 = rs2;
  assign bus_n.WriteSelect = ws;
  assign bus_n.WriteData   = wd;
  assign bus_n.RegWrite    = we;

  reg_file_32x64 #(.WIDTH(64), .BYPASS(1'b1), .ZERO_REG(31)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  reg_file_32x64 #(.WIDTH(64), .BYPASS(1'b0), .ZERO_REG(31)) dut_n (
    .clock (clock),
    .reset (reset),
    .bus   (bus_n)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Single write committed on the next rising edge, then write enable dropped
  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    ws = a;
    wd = d;
    we = 1'b1;
    @(posedge clock);
    #1;
    we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    clock = 1'b0;
    reset = 1'b0;
    rs1 = '0; rs2 = '0; ws = '0; wd = '0; we = 1'b0;
    #1 reset = 1'b1;
    #1;

    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      chk($sformatf("rst_rd1[%0d]", i), bus_b.ReadData1, 64'h0);
      chk($sformatf("rst_rd2[%0d]", 31 - i), bus_b.ReadData2, 64'h0);
    end
    chk("rst_wcount", {48'h0, bus_b.WriteCount}, 64'h0);

    // Write presented while reset is held must be dropped
    ws = 5'd4; wd = 64'h99; we = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    we    = 1'b0;
    rs1   = 5'd4;
    #1;
    chk("rst_write_dropped", bus_b.ReadData1, 64'h0);
    chk("rst_write_nocount", {48'h0, bus_b.WriteCount}, 64'h0);

    wr(5'd5, 64'hDEADBEEF_CAFEF00D);
    wr(5'd30, 64'h1);
    rs1 = 5'd5;
    rs2 = 5'd30;
    #1;
    chk("rdback_x5", bus_b.ReadData1, 64'hDEADBEEF_CAFEF00D);
    chk("rdback_x30", bus_b.ReadData2, 64'h1);
    chk("rdback_wcount", {48'h0, bus_b.WriteCount}, 64'd2);

    // XZR reads zero before and after a write attempt
    rs1 = 5'd31; ws = 5'd31; wd = 64'hFFFF_FFFF_FFFF_FFFF; we = 1'b1;
    #1;
    chk("xzr_pre_edge", bus_b.ReadData1, 64'h0);
    @(posedge clock);
    #1;
    we = 1'b0;
    #1;
    chk("xzr_post_edge", bus_b.ReadData1, 64'h0);
    chk("xzr_wcount", {48'h0, bus_b.WriteCount}, 64'd2);

    wr(5'd7, 64'hAA);
    ws = 5'd7; wd = 64'h55; we = 1'b1; rs1 = 5'd7; rs2 = 5'd7;
    #1;
    chk("byp1_rd1", bus_b.ReadData1, 64'h55);
    chk("byp1_rd2", bus_b.ReadData2, 64'h55);
    chk("byp0_rd1_pre", bus_n.ReadData1, 64'hAA);
    chk("byp0_rd2_pre", bus_n.ReadData2, 64'hAA);
    rs2 = 5'd5;
    #1;
    chk("byp1_other_port", bus_b.ReadData2, 64'hDEADBEEF_CAFEF00D);
    @(posedge clock);
    #1;
    we  = 1'b0;
    rs2 = 5'd7;
    #1;
    chk("byp0_rd1_post", bus_n.ReadData1, 64'h55);
    chk("byp0_rd2_post", bus_n.ReadData2, 64'h55);
    chk("byp1_rd1_post", bus_b.ReadData1, 64'h55);
    chk("byp_wcount", {48'h0, bus_b.WriteCount}, 64'd4);

    // Async reset raised between edges
    wr(5'd3, 64'h1234);
    rs1 = 5'd3;
    #1;
    chk("x3_before_reset", bus_b.ReadData1, 64'h1234);
    reset = 1'b1;
    #1;
    chk("x3_async_clear", bus_b.ReadData1, 64'h0);
    chk("async_wcount", {48'h0, bus_b.WriteCount}, 64'h0);
    ws = 5'd9; wd = 64'h77; we = 1'b1; rs1 = 5'd9;
    #1;
    chk("reset_no_bypass", bus_b.ReadData1, 64'h0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    we    = 1'b0;
    #1;
    chk("reset_x9_dropped", bus_b.ReadData1, 64'h0);
    rs1 = 5'd5;
    #1;
    chk("reset_x5_cleared", bus_b.ReadData1, 64'h0);

    // Saturating counter: 65540 consecutive writes to X1
    ws = 5'd1;
    we = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      wd = 64'(i);
      @(posedge clock);
      #1;
      if (i == 65533) chk("sat_near", {48'h0, bus_b.WriteCount}, 64'd65534);
    end
    we  = 1'b0;
    rs1 = 5'd1;
    #1;
    chk("sat_wcount", {48'h0, bus_b.WriteCount}, 64'hFFFF);
    chk("sat_x1_last", bus_b.ReadData1, 64'd65539);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
